// File: rtl/adxl345_pkg.sv
// Register map, command encodings and shared types for the ADXL345 sequencer.
package adxl345_pkg;

    localparam logic [7:0] REG_DEVID       = 8'h00;
    localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
    localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
    localparam logic [7:0] REG_DATAX0      = 8'h32;

    localparam logic [7:0] CMD_READ = 8'h80;
    localparam logic [7:0] CMD_MB   = 8'h40;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWrFmt  = 3'd1,
        StWrPwr  = 3'd2,
        StRdId   = 3'd3,
        StChk    = 3'd4,
        StWait   = 3'd5,
        StRdAxis = 3'd6,
        StErr    = 3'd7
    } state_e;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] wdata;
        logic [3:0] nwr;
        logic [3:0] nrd;
    } cmd_t;

endpackage

// File: rtl/adxl345_axis_assembler.sv
// Counts received MISO bytes, captures them into a shadow register and publishes XYZ
// samples once a complete 6-byte burst has arrived.
module adxl345_axis_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        capture,
    input  logic [3:0]  nrd,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        finish,
    output logic [7:0]  id_byte,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        sample_valid
);

    logic [2:0]  idx;
    logic [2:0]  idx_next;
    logic [47:0] shadow;
    logic [47:0] shadow_next;
    logic        take;
    logic        publish;

    // A byte arriving together with the completion strobe is counted before publishing.
    always_comb begin
        take        = capture && rx_valid && ({1'b0, idx} < nrd);
        idx_next    = idx;
        shadow_next = shadow;
        if (take) begin
            idx_next                         = idx + 3'd1;
            shadow_next[{idx, 3'b000} +: 8] = rx_byte;
        end
        publish = finish && (idx_next == 3'd6);
        id_byte = shadow_next[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            shadow       <= '0;
            accel_x      <= '0;
            accel_y      <= '0;
            accel_z      <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= publish;
            if (clear) begin
                idx    <= '0;
                shadow <= '0;
            end else begin
                idx    <= idx_next;
                shadow <= shadow_next;
            end
            if (publish) begin
                accel_x <= shadow_next[15:0];
                accel_y <= shadow_next[31:16];
                accel_z <= shadow_next[47:32];
            end
        end
    end

endmodule

// File: rtl/adxl345_seq_ctrl.sv
// ADXL345 sequencer: bring-up writes, DEVID check, then periodic 6-byte XYZ burst reads
// issued to an external SPI transaction engine.
module adxl345_seq_ctrl
    import adxl345_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV  = 100000,
    parameter int unsigned TIMEOUT_CYC = 4095,
    parameter logic [7:0]  FORMAT_VAL  = 8'h08,
    parameter logic [7:0]  POWER_VAL   = 8'h08,
    parameter logic [7:0]  DEVID_VAL   = 8'hE5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        spi_start,
    output logic [7:0]  spi_cmd,
    output logic [7:0]  spi_wdata,
    output logic [3:0]  spi_bytes_to_write,
    output logic [3:0]  spi_bytes_to_read,
    input  logic        spi_rx_valid,
    input  logic [7:0]  spi_rx_byte,
    input  logic        spi_done,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        sample_valid,
    output logic        init_done,
    output logic        dev_err,
    output logic [2:0]  state_dbg
);

    localparam int unsigned PW = $clog2(SAMPLE_DIV);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] PDIV_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    localparam cmd_t CMD_WR_FMT  = '{cmd: REG_DATA_FORMAT, wdata: FORMAT_VAL, nwr: 4'd2, nrd: 4'd0};
    localparam cmd_t CMD_WR_PWR  = '{cmd: REG_POWER_CTL, wdata: POWER_VAL, nwr: 4'd2, nrd: 4'd0};
    localparam cmd_t CMD_RD_ID   = '{cmd: CMD_READ | REG_DEVID, wdata: 8'h00, nwr: 4'd1, nrd: 4'd1};
    localparam cmd_t CMD_RD_AXIS = '{cmd: CMD_READ | CMD_MB | REG_DATAX0, wdata: 8'h00,
                                     nwr: 4'd1, nrd: 4'd6};

    state_e        state;
    cmd_t          xfer;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic [7:0]    id_byte;
    logic          capture;
    logic          axis_finish;

    // ISSUE is exactly the spi_start cycle; every other cycle of a transaction state is PEND.
    always_comb begin
        capture     = ((state == StRdId) || (state == StRdAxis)) && !spi_start;
        axis_finish = (state == StRdAxis) && !spi_start && spi_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            spi_start <= 1'b0;
            xfer      <= '0;
            pcnt      <= '0;
            tcnt      <= '0;
            init_done <= 1'b0;
            dev_err   <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            // Saturates so an overlong burst relaunches right after its completion.
            if (pcnt != PDIV_LAST) pcnt <= pcnt + PW'(1);
            tcnt <= spi_start ? '0 : tcnt + TW'(1);
            unique case (state)
                StIdle: begin
                    if (start && init_done) begin
                        state <= StWait;
                        pcnt  <= '0;
                    end else if (start) begin
                        state     <= StWrFmt;
                        spi_start <= 1'b1;
                        xfer      <= CMD_WR_FMT;
                    end
                end
                StWrFmt, StWrPwr, StRdId, StRdAxis: begin
                    if (!spi_start && spi_done) begin
                        if (state == StRdId && id_byte != DEVID_VAL) begin
                            dev_err <= 1'b1;
                            state   <= StChk;
                        end else if (!start) begin
                            state <= StIdle;
                        end else if (state == StWrFmt) begin
                            state     <= StWrPwr;
                            spi_start <= 1'b1;
                            xfer      <= CMD_WR_PWR;
                        end else if (state == StWrPwr) begin
                            state     <= StRdId;
                            spi_start <= 1'b1;
                            xfer      <= CMD_RD_ID;
                        end else if (state == StRdId) begin
                            init_done <= 1'b1;
                            state     <= StChk;
                        end else if (pcnt == PDIV_LAST) begin
                            spi_start <= 1'b1;
                            pcnt      <= '0;
                        end else begin
                            state <= StWait;
                        end
                    end else if (!spi_start && tcnt == TO_LAST) begin
                        dev_err <= 1'b1;
                        state   <= StErr;
                    end
                end
                StChk: begin
                    if (dev_err) begin
                        state <= StErr;
                    end else begin
                        state <= StWait;
                        pcnt  <= '0;
                    end
                end
                StWait: begin
                    if (!start) begin
                        state <= StIdle;
                    end else if (pcnt == PDIV_LAST) begin
                        state     <= StRdAxis;
                        spi_start <= 1'b1;
                        xfer      <= CMD_RD_AXIS;
                        pcnt      <= '0;
                    end
                end
                StErr: begin
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        spi_cmd            = xfer.cmd;
        spi_wdata          = xfer.wdata;
        spi_bytes_to_write = xfer.nwr;
        spi_bytes_to_read  = xfer.nrd;
        state_dbg          = state;
    end

    adxl345_axis_assembler u_assembler (
        .clk          (clk),
        .rst          (rst),
        .clear        (spi_start),
        .capture      (capture),
        .nrd          (xfer.nrd),
        .rx_valid     (spi_rx_valid),
        .rx_byte      (spi_rx_byte),
        .finish       (axis_finish),
        .id_byte      (id_byte),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .sample_valid (sample_valid)
    );

endmodule

// File: tb/tb_adxl345_seq_ctrl.sv
// Scoreboard bench for adxl345_seq_ctrl: a model SPI slave answers each launch, monitors pop
// expected transactions and samples from queues filled by the directed stimulus.
module tb_adxl345_seq_ctrl;

    localparam int SDIV = 64;
    localparam int TOUT = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        spi_start;
    logic [7:0]  spi_cmd;
    logic [7:0]  spi_wdata;
    logic [3:0]  spi_bytes_to_write;
    logic [3:0]  spi_bytes_to_read;
    logic        spi_rx_valid;
    logic [7:0]  spi_rx_byte;
    logic        spi_done;
    logic [15:0] accel_x;
    logic [15:0] accel_y;
    logic [15:0] accel_z;
    logic        sample_valid;
    logic        init_done;
    logic        dev_err;
    logic [2:0]  state_dbg;

    adxl345_seq_ctrl #(
        .SAMPLE_DIV  (SDIV),
        .TIMEOUT_CYC (TOUT),
        .FORMAT_VAL  (8'h08),
        .POWER_VAL   (8'h08),
        .DEVID_VAL   (8'hE5)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .spi_start          (spi_start),
        .spi_cmd            (spi_cmd),
        .spi_wdata          (spi_wdata),
        .spi_bytes_to_write (spi_bytes_to_write),
        .spi_bytes_to_read  (spi_bytes_to_read),
        .spi_rx_valid       (spi_rx_valid),
        .spi_rx_byte        (spi_rx_byte),
        .spi_done           (spi_done),
        .accel_x            (accel_x),
        .accel_y            (accel_y),
        .accel_z            (accel_z),
        .sample_valid       (sample_valid),
        .init_done          (init_done),
        .dev_err            (dev_err),
        .state_dbg          (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] wdata;
        logic       chk_wdata;
        logic [3:0] nwr;
        logic [3:0] nrd;
    } txn_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } smp_t;

    txn_t txn_q[$];
    smp_t smp_q[$];
    int   rd_launch[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_launch = 0;
    int last_launch_cyc = -1;
    int id_done_cyc = -1;
    int init_rise_cyc = -1;
    int err_rise_cyc = -1;

    // Slave model configuration
    logic [7:0] sl_devid;
    logic [7:0] sl_burst [6];
    int         sl_naxis;
    bit         sl_mute;
    int         sl_n;
    logic [3:0] sl_rd;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic void push_txn(input logic [7:0] c, input logic [7:0] w, input logic cw,
                                     input logic [3:0] nw, input logic [3:0] nr);
        txn_t t;
        t.cmd = c; t.wdata = w; t.chk_wdata = cw; t.nwr = nw; t.nrd = nr;
        txn_q.push_back(t);
    endfunction

    function automatic void push_bringup();
        push_txn(8'h31, 8'h08, 1'b1, 4'd2, 4'd0);
        push_txn(8'h2D, 8'h08, 1'b1, 4'd2, 4'd0);
        push_txn(8'h80, 8'h00, 1'b0, 4'd1, 4'd1);
    endfunction

    function automatic void push_rd();
        push_txn(8'hF2, 8'h00, 1'b0, 4'd1, 4'd6);
    endfunction

    function automatic void push_smp(input logic [15:0] x, input logic [15:0] y,
                                     input logic [15:0] z);
        smp_t s;
        s.x = x; s.y = y; s.z = z;
        smp_q.push_back(s);
    endfunction

    function automatic logic [7:0] slave_byte(input int i);
        if (i < 0) return 8'h00;
        if (sl_rd == 4'd1) return sl_devid;
        return sl_burst[i];
    endfunction

    task automatic wait_txn_drain(input string nm, input int budget);
        int n = 0;
        while (txn_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, txn_q.size(), 0);
    endtask

    task automatic wait_smp_drain(input string nm, input int budget);
        int n = 0;
        while (smp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, smp_q.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Model SPI slave: bytes every other cycle, the last one coinciding with spi_done.
    initial begin
        spi_rx_valid = 1'b0;
        spi_rx_byte  = 8'h00;
        spi_done     = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1 && !sl_mute) begin
                sl_rd = spi_bytes_to_read;
                sl_n  = (sl_rd == 4'd1) ? 1 : ((sl_rd == 4'd6) ? sl_naxis : 0);
                @(posedge clk); #1;
                for (int i = 0; i < sl_n - 1; i++) begin
                    spi_rx_valid = 1'b1;
                    spi_rx_byte  = slave_byte(i);
                    @(posedge clk); #1;
                    spi_rx_valid = 1'b0;
                    @(posedge clk); #1;
                end
                spi_rx_valid = (sl_n > 0);
                spi_rx_byte  = slave_byte(sl_n - 1);
                spi_done     = 1'b1;
                @(posedge clk); #1;
                spi_rx_valid = 1'b0;
                spi_done     = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT launches or publishes.
    initial begin
        txn_t t;
        smp_t s;
        logic init_prev = 1'b0;
        logic err_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && spi_start) begin
                n_launch++;
                last_launch_cyc = cyc;
                if (spi_cmd == 8'hF2) rd_launch.push_back(cyc);
                if (txn_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_launch: actual cmd %0h required no launch", spi_cmd);
                end else begin
                    t = txn_q.pop_front();
                    check("txn_cmd", spi_cmd, t.cmd);
                    if (t.chk_wdata) check("txn_wdata", spi_wdata, t.wdata);
                    check("txn_nwr", spi_bytes_to_write, t.nwr);
                    check("txn_nrd", spi_bytes_to_read, t.nrd);
                end
            end
            if (!rst && sample_valid) begin
                if (smp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: actual x %0h required no sample", accel_x);
                end else begin
                    s = smp_q.pop_front();
                    check("accel_x", accel_x, s.x);
                    check("accel_y", accel_y, s.y);
                    check("accel_z", accel_z, s.z);
                end
            end
            if (spi_done && state_dbg == 3'd3) id_done_cyc = cyc;
            if (init_done && !init_prev) init_rise_cyc = cyc;
            if (dev_err && !err_prev) err_rise_cyc = cyc;
            init_prev = init_done;
            err_prev  = dev_err;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        sl_devid = 8'hE5;
        sl_naxis = 6;
        sl_mute  = 1'b0;
        sl_burst = '{8'h34, 8'h12, 8'hCE, 8'hFF, 8'h00, 8'h01};
        repeat (3) @(negedge clk);
        check("reset_ctrl", {spi_start, init_done, dev_err, sample_valid, state_dbg, spi_cmd,
                             spi_wdata, spi_bytes_to_write, spi_bytes_to_read}, 64'd0);
        check("reset_accel", {accel_x, accel_y, accel_z}, 64'd0);

        // Bring-up with good DEVID, then periodic bursts
        push_bringup();
        push_rd();
        push_smp(16'h1234, 16'hFFCE, 16'h0100);
        push_rd();
        push_smp(16'h1234, 16'hFFCE, 16'h0100);
        rst   = 1'b0;
        start = 1'b1;
        wait_txn_drain("bringup_and_reads", 1000);
        wait_smp_drain("first_samples", 200);
        check("init_after_devid_done", init_rise_cyc, id_done_cyc + 1);
        check("init_done_high", init_done, 1'b1);
        check("dev_err_low", dev_err, 1'b0);

        // Short burst: no publish, schedule kept
        sl_naxis = 4;
        push_rd();
        wait_txn_drain("short_read_launch", 200);
        repeat (20) @(negedge clk);
        check("accel_held", {accel_x, accel_y, accel_z}, {16'h1234, 16'hFFCE, 16'h0100});
        check("short_read_no_err", dev_err, 1'b0);
        sl_naxis = 6;
        sl_burst = '{8'h00, 8'h80, 8'hFF, 8'h7F, 8'h01, 8'h00};
        push_rd();
        push_smp(16'h8000, 16'h7FFF, 16'h0001);
        wait_txn_drain("read_after_short", 200);
        wait_smp_drain("sample_after_short", 200);
        check("read_launch_count", rd_launch.size(), 4);
        for (int i = 0; i + 1 < rd_launch.size(); i++)
            check("read_period", rd_launch[i+1] - rd_launch[i], SDIV);
        rd_launch.delete();

        // Drop start in WAIT, resume without bring-up
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_drop", state_dbg, 3'd0);
        check("init_held_after_drop", init_done, 1'b1);
        start = 1'b1;
        push_rd();
        push_smp(16'h8000, 16'h7FFF, 16'h0001);
        wait_txn_drain("resume_read", 200);
        wait_smp_drain("resume_sample", 200);

        // Reset in the middle of a burst
        push_rd();
        wait_txn_drain("read_before_reset", 200);
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("midreset_ctrl", {spi_start, init_done, dev_err, sample_valid, state_dbg, spi_cmd,
                                spi_wdata, spi_bytes_to_write, spi_bytes_to_read}, 64'd0);
        check("midreset_accel", {accel_x, accel_y, accel_z}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("idle_after_stale_done", state_dbg, 3'd0);
        push_bringup();
        push_rd();
        push_smp(16'h8000, 16'h7FFF, 16'h0001);
        start = 1'b1;
        wait_txn_drain("rebringup", 400);
        start = 1'b0;
        wait_smp_drain("rebringup_sample", 200);
        repeat (5) @(negedge clk);
        check("idle_after_last_read", state_dbg, 3'd0);

        // Bad DEVID
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        sl_devid = 8'hFF;
        push_bringup();
        start = 1'b1;
        wait_txn_drain("bad_id_bringup", 300);
        repeat (20) @(negedge clk);
        check("bad_id_dev_err", dev_err, 1'b1);
        check("bad_id_init_done", init_done, 1'b0);
        check("bad_id_state_err", state_dbg, 3'd7);
        n0 = n_launch;
        repeat (10 * SDIV) @(negedge clk);
        check("err_no_launch", n_launch, n0);

        // Timeout: slave never completes
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        sl_mute      = 1'b1;
        sl_devid     = 8'hE5;
        err_rise_cyc = -1;
        push_txn(8'h31, 8'h08, 1'b1, 4'd2, 4'd0);
        start = 1'b1;
        wait_txn_drain("timeout_launch", 50);
        n = 0;
        while (err_rise_cyc < 0 && n < 3 * TOUT) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycle", err_rise_cyc, last_launch_cyc + 1 + TOUT);
        @(negedge clk);
        check("timeout_state_err", state_dbg, 3'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
